// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and load/store ports, one grant per cycle.
// Define SP_RAM_ARB_RR_EN for round-robin arbitration; default is instr priority with a data starvation guard.
module sp_ram_arbiter #(
  parameter int          MEM_SIZE     = 65536,
  parameter logic [31:0] MEM_START    = 32'h0000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        instr_req,
  output logic        instr_gnt,
  input  logic [31:0] instr_addr,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] WIN_MASK = ~(32'(MEM_SIZE) - 32'd1);

  logic data_win;
  logic instr_in_win;
  logic data_in_win;
  logic trk_valid;
  logic trk_data;
  logic trk_err;

  // RAM responses have fixed one-cycle latency, so the tracker alone times the reply.
  logic unused_mem_rvalid;
  assign unused_mem_rvalid = mem_rvalid;

  assign instr_in_win = (instr_addr & WIN_MASK) == MEM_START;
  assign data_in_win  = (data_addr & WIN_MASK) == MEM_START;

`ifdef SP_RAM_ARB_RR_EN
  logic last_data;

  assign data_win = data_req && (!instr_req || !last_data);

  // Reset value "data" lets instr take the first contended cycle.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      last_data <= 1'b1;
    end else if (instr_req && data_req) begin
      last_data <= data_win;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign data_win = data_req && (!instr_req || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      starve_cnt <= 4'd0;
    end else if (!data_req || data_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  assign data_gnt  = data_win && !rst_sys;
  assign instr_gnt = instr_req && !data_win && !rst_sys;

  // Out-of-window grants never touch the RAM; only the error response is scheduled.
  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (data_gnt && data_in_win) begin
      mem_req   = 1'b1;
      mem_write = data_we;
      mem_be    = data_be;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (instr_gnt && instr_in_win) begin
      mem_req   = 1'b1;
      mem_be    = 4'hF;
      mem_addr  = instr_addr;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      trk_valid <= 1'b0;
      trk_data  <= 1'b0;
      trk_err   <= 1'b0;
    end else begin
      trk_valid <= instr_gnt || data_gnt;
      trk_data  <= data_gnt;
      trk_err   <= data_gnt ? !data_in_win : !instr_in_win;
    end
  end

  assign instr_rvalid = trk_valid && !trk_data;
  assign instr_err    = instr_rvalid && trk_err;
  assign instr_rdata  = (instr_rvalid && !trk_err) ? mem_rdata : 32'h0;

  assign data_rvalid  = trk_valid && trk_data;
  assign data_err     = data_rvalid && trk_err;
  assign data_rdata   = (data_rvalid && !trk_err) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_sp_ram_arbiter;
  logic        clk_sys;
  logic        rst_sys;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_write, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        is_data;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] ram [0:1023];

  sp_ram_arbiter #(
    .MEM_SIZE(65536), .MEM_START(32'h0000_0000), .STARVE_LIMIT(4)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_addr(instr_addr),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_write(mem_write), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // RAM model: one-cycle read latency, garbage on idle cycles so stray forwarding shows up.
  always @(posedge clk_sys) begin
    mem_rvalid <= mem_req;
    if (mem_req && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= 32'h0;
    end else if (mem_req) begin
      mem_rdata <= ram[mem_addr[11:2]];
    end else begin
      mem_rdata <= 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    rsp_t e;
    if (instr_rvalid && data_rvalid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL both_rvalid: got 1 expected 0 at %0t", $time);
    end else if (instr_rvalid || data_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got instr=%0b data=%0b expected none at %0t",
                 instr_rvalid, data_rvalid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", {31'h0, data_rvalid}, {31'h0, e.is_data});
        if (e.is_data) begin
          chk("data_err", {31'h0, data_err}, {31'h0, e.err});
          chk("data_rdata", data_rdata, e.rdata);
          chk("instr_idle_fields", {instr_rdata[30:0], instr_err}, 32'h0);
        end else begin
          chk("instr_err", {31'h0, instr_err}, {31'h0, e.err});
          chk("instr_rdata", instr_rdata, e.rdata);
          chk("data_idle_fields", {data_rdata[30:0], data_err}, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_data_win(input int k);
`ifdef SP_RAM_ARB_RR_EN
    return (k % 2) == 1;
`else
    return (k % 5) == 4;
`endif
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_idle();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  task automatic go_instr(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    drive_idle();
    instr_req = 1'b1;
    instr_addr = addr;
    #2;
    chk("instr_gnt", {31'h0, instr_gnt}, 32'h1);
    chk("data_gnt_idle", {31'h0, data_gnt}, 32'h0);
    chk("instr_mem_req", {31'h0, mem_req}, {31'h0, !exp_err});
    if (!exp_err) begin
      chk("instr_mem_addr", mem_addr, addr);
      chk("instr_mem_we_be", {27'h0, mem_write, mem_be}, 32'h0F);
    end
    exp_q.push_back('{is_data: 1'b0, err: exp_err, rdata: exp_rd});
  endtask

  task automatic go_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    drive_idle();
    data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
    #2;
    chk("data_gnt", {31'h0, data_gnt}, 32'h1);
    chk("instr_gnt_idle", {31'h0, instr_gnt}, 32'h0);
    chk("data_mem_req", {31'h0, mem_req}, {31'h0, !exp_err});
    if (!exp_err) begin
      chk("data_mem_addr", mem_addr, addr);
      chk("data_mem_we_be", {27'h0, mem_write, mem_be}, {27'h0, we, be});
      if (we) chk("data_mem_wdata", mem_wdata, wd);
    end
    exp_q.push_back('{is_data: 1'b1, err: exp_err, rdata: exp_rd});
  endtask

  task automatic contend(input int n, input int push_n);
    logic dwin;
    for (int k = 0; k < n; k++) begin
      step();
      drive_idle();
      instr_req = 1'b1; instr_addr = 32'h0000_0010;
      data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_0100;
      #2;
      dwin = exp_data_win(k);
      chk($sformatf("contend%0d_data_gnt", k), {31'h0, data_gnt}, {31'h0, dwin});
      chk($sformatf("contend%0d_instr_gnt", k), {31'h0, instr_gnt}, {31'h0, !dwin});
      if (k > 0)
        chk($sformatf("contend%0d_no_bubble", k), {31'h0, instr_rvalid || data_rvalid}, 32'h1);
      if (k < push_n)
        exp_q.push_back('{is_data: dwin, err: 1'b0,
                          rdata: dwin ? 32'h0000_BEEF : 32'h0000_0013});
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[4]    = 32'h0000_0013;
    ram[1023] = 32'hCAFE_F00D;
    rst_sys = 1'b1;
    drive_idle();
    repeat (2) step();
    instr_req = 1'b1;
    #2;
    chk("rst_instr_gnt", {31'h0, instr_gnt}, 32'h0);
    chk("rst_data_gnt", {31'h0, data_gnt}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_rvalid_err", {28'h0, instr_rvalid, data_rvalid, instr_err, data_err}, 32'h0);
    chk("rst_instr_rdata", instr_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);

    step();
    rst_sys = 1'b0;
    go_instr(32'h0000_0010, 32'h0000_0013, 1'b0);
    step(); go_data(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step(); go_data(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_BEEF, 1'b0);
    step(); go_data(1'b0, 4'hF, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
    step(); go_instr(32'h0000_FFFC, 32'hCAFE_F00D, 1'b0);
    step(); go_instr(32'h0001_0000, 32'h0, 1'b1);

    contend(10, 10);

    // Last granted read of this burst is dropped by the reset that follows.
    contend(3, 2);
    step();
    drive_idle();
    rst_sys = 1'b1;
    #2;
    chk("rst_mid_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    step();
    #2;
    chk("rst_hold_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    step();
    rst_sys = 1'b0;
    #2;
    chk("rst_rel_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    step();
    #2;
    chk("post_rel_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    contend(5, 5);

    step();
    drive_idle();
    repeat (3) step();
    chk("pending_rsp", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-port to single-port memory arbiter that shares the testbench's single-port RAM between the Ibex instruction fetch port and the Ibex load/store port. It grants at most one access per cycle and bounds data-port starvation. It returns each response to the port that issued the access, and answers out-of-window addresses with an error response. It sits between the core's instr/data request interfaces and the RAM model inside the verification BFM.

## Interface
- MEM_SIZE, 65536: RAM window size in bytes; power of two.
- MEM_START, 32'h00000000: window base address; aligned to MEM_SIZE.
- STARVE_LIMIT, 4: consecutive stalled data cycles before the data port is forced to win; range 1..15.

- clk_sys  in  1  system clock; all state updates on rising edge
- rst_sys  in  1  asynchronous, active-high reset
- instr_req / instr_gnt  in / out  1  instruction request / same-cycle grant
- instr_addr  in  32  instruction byte address
- instr_rvalid  out  1  instruction response valid
- instr_rdata  out  32  instruction read data
- instr_err  out  1  instruction response error (out-of-window)
- data_req / data_gnt  in / out  1  data request / same-cycle grant
- data_we  in  1  1 = write
- data_be  in  4  byte enables
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_rvalid  out  1  data response valid (reads and writes)
- data_rdata  out  32  data read data
- data_err  out  1  data response error
- mem_req  out  1  RAM access strobe
- mem_write  out  1  RAM write enable
- mem_be  out  4  RAM byte enables
- mem_addr  out  32  RAM byte address
- mem_wdata  out  32  RAM write data
- mem_rvalid  in  1  RAM response; exactly one cycle after mem_req
- mem_rdata  in  32  RAM read data

## Operation
- Winner select is combinational each cycle from instr_req, data_req, and arbitration state. The winner's gnt is asserted in the same cycle. The loser's gnt is 0. The loser's requester holds req and its attributes stable until granted.
- In-window test: (addr & ~(MEM_SIZE-1)) == MEM_START.
- Granted in-window access: mem_req=1 and winner's fields drive mem_*.
- Instruction grants always drive mem_write=0 and mem_be=4'hF.
- Granted out-of-window access: mem_req=0, and an error response is still scheduled.
- When no access is granted, all mem_* outputs are 0.
- Response tracker is registered each cycle and holds: valid, owner (instr/data), and err.
- Next cycle:
  - The owner's rvalid=1 and err = the registered err.
  - Owner's rdata = mem_rdata if err=0, else 32'h0.
  - The non-owner's rvalid, err and rdata are all 0.
- A grant may be issued every cycle (fully pipelined); the tracker needs no stall.
- Default arbitration is instruction priority with a starvation guard:
  - starve_cnt increments when data_req=1 and data_gnt=0, saturating at STARVE_LIMIT.
  - starve_cnt clears on data_gnt or when data_req=0.
  - When starve_cnt == STARVE_LIMIT and data_req=1, data wins over instr.
- A lone requester always wins.
- mem_rvalid is not checked against the tracker.

## Timing
- Reset values:
  - gnt, rvalid and err on both ports = 0; rdata on both ports = 0.
  - Tracker valid = 0, starve_cnt = 0, last-winner = data (instr wins the first contended cycle under round-robin).
- Grant latency is 0 cycles (combinational from req). Response latency is exactly 1 cycle after grant.
- Reset asserted mid-operation: pending response is dropped; no rvalid follows reset release.
- The first grant is possible in the first cycle after rst_sys deasserts.
- Simultaneous requests under default arbitration: instr wins unless starve_cnt==STARVE_LIMIT.
- Data forced-win cycle: instr_gnt=0 and the instr request is held.
- Back-to-back grants to alternating owners produce alternating rvalid with no bubble.

## Configuration
- SP_RAM_ARB_RR_EN defined: round-robin arbitration.
  - Under contention, the port that did not win the last contended cycle wins.
  - The last-winner flag updates only on contended cycles.
  - starve_cnt is absent (tied 0); STARVE_LIMIT is ignored.
- Not defined: instruction priority with starvation guard as described under Operation.

## Test plan
- Reset then single fetch: instr_req=1, addr=32'h0000_0010, mem_rdata=32'h0000_0013 → same-cycle instr_gnt=1, mem_addr=32'h10, mem_req=1; next cycle instr_rvalid=1, instr_rdata=32'h13, data_rvalid=0.
- Data write, addr=32'h0000_0100, we=1, be=4'h3, wdata=32'hDEAD_BEEF → mem_write=1, mem_be=4'h3, mem_wdata=32'hDEADBEEF; next cycle data_rvalid=1, data_err=0.
- Out-of-window: data_req=1, addr=32'h0001_0000 (MEM_SIZE=64 kB) → data_gnt=1, mem_req=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
- Starvation (default build, STARVE_LIMIT=4): instr_req and data_req held high → instr granted cycles 0-3, data granted cycle 4, instr cycle 5. The pattern repeats every 5 cycles.
- Round-robin build: both requests held high for 6 cycles → grants alternate I,D,I,D,I,D, with matching alternating rvalids one cycle later.
- Reset mid-operation: rst_sys=1 in the cycle after a granted read → no rvalid on either port during reset or after release. starve_cnt=0 after release.
